// File: rtl/systolic_feeder.sv
// systolic_feeder
//   N x N operand feeder for a systolic MAC array. One A column and one B row
//   are accepted per beat over a valid/ready handshake. Row i / column j are
//   skewed by i / j cycles so that A element i and B element j meet at
//   PE(i,j) exactly i+j edges after acceptance, together with valid/first
//   flags. After the last beat of a matrix the grid drains with zeros for
//   2N-2 edges, then done pulses.
//
// Parameters: OP_WIDTH (operand bits), N (array dimension, >= 2),
//             K_MAX (beats per matrix; the K_MAX-th beat is forced last)
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     beat handshake; in_last marks final beat
//   in_a_col, in_b_row    N operands each, element k at [k*OP_WIDTH +: OP_WIDTH]
//   mac_a, mac_b          per-PE operands, PE(i,j) at [(i*N+j)*OP_WIDTH +: OP_WIDTH]
//   pe_valid, pe_first    per-PE flags, bit i*N+j
//   busy, done            FEED/DRAIN indicator, end-of-matrix pulse
//   k_count               beats accepted in current matrix
//   stall_cycles          (only with SYSTOLIC_FEEDER_STATS_EN) FEED cycles
//                         without in_valid, saturating, cleared on first beat
//
// Optional feature macro: SYSTOLIC_FEEDER_STATS_EN

module systolic_feeder #(
  parameter int OP_WIDTH = 8,
  parameter int N        = 4,
  parameter int K_MAX    = 256,
  localparam int KW      = $clog2(K_MAX + 1),
  localparam int DW      = $clog2(2 * N - 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [N*OP_WIDTH-1:0]      in_a_col,
  input  logic [N*OP_WIDTH-1:0]      in_b_row,
  output logic [N*N*OP_WIDTH-1:0]    mac_a,
  output logic [N*N*OP_WIDTH-1:0]    mac_b,
  output logic [N*N-1:0]             pe_valid,
  output logic [N*N-1:0]             pe_first,
  output logic                       busy,
  output logic                       done,
  output logic [KW-1:0]              k_count
`ifdef SYSTOLIC_FEEDER_STATS_EN
  ,
  output logic [15:0]                stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  localparam logic [KW-1:0] K_LAST = KW'(K_MAX - 1);
  localparam logic [DW-1:0] D_LAST = DW'(2 * N - 3);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          accept;
  logic          inj_first;

  assign in_ready  = (state != DRAIN);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign inj_first = accept && (k_count == '0);

  // Each row pipe has i skew stages followed by N PE stages, so stage i+j
  // feeds PE(i,j). The flags travel with A since A and B arrive together.
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [OP_WIDTH-1:0] a_pipe [i+N];
    logic                v_pipe [i+N];
    logic                f_pipe [i+N];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < i + N; s++) begin
          a_pipe[s] <= '0;
          v_pipe[s] <= 1'b0;
          f_pipe[s] <= 1'b0;
        end
      end else begin
        a_pipe[0] <= accept ? in_a_col[i*OP_WIDTH +: OP_WIDTH] : '0;
        v_pipe[0] <= accept;
        f_pipe[0] <= inj_first;
        for (int s = 1; s < i + N; s++) begin
          a_pipe[s] <= a_pipe[s-1];
          v_pipe[s] <= v_pipe[s-1];
          f_pipe[s] <= f_pipe[s-1];
        end
      end
    end

    for (genvar j = 0; j < N; j++) begin : g_pe
      assign mac_a[(i*N+j)*OP_WIDTH +: OP_WIDTH] = a_pipe[i+j];
      assign pe_valid[i*N+j]                     = v_pipe[i+j];
      assign pe_first[i*N+j]                     = f_pipe[i+j];
    end
  end

  // Column pipes mirror the row pipes for B: stage j+i feeds PE(i,j).
  for (genvar j = 0; j < N; j++) begin : g_col
    logic [OP_WIDTH-1:0] b_pipe [j+N];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < j + N; s++) b_pipe[s] <= '0;
      end else begin
        b_pipe[0] <= accept ? in_b_row[j*OP_WIDTH +: OP_WIDTH] : '0;
        for (int s = 1; s < j + N; s++) b_pipe[s] <= b_pipe[s-1];
      end
    end

    for (genvar i = 0; i < N; i++) begin : g_pe
      assign mac_b[(i*N+j)*OP_WIDTH +: OP_WIDTH] = b_pipe[j+i];
    end
  end

  // The last beat needs 2N-2 further edges to reach PE(N-1,N-1); done is
  // registered on that final edge so it coincides with those operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k_count   <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            k_count   <= KW'(1);
            drain_cnt <= '0;
            state     <= (in_last || K_MAX == 1) ? DRAIN : FEED;
          end
        end
        FEED: begin
          if (accept) begin
            k_count   <= k_count + 1'b1;
            drain_cnt <= '0;
            if (in_last || k_count == K_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == D_LAST) begin
            state     <= IDLE;
            done      <= 1'b1;
            k_count   <= '0;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_FEEDER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (state == IDLE && accept) begin
      stall_cycles <= '0;
    end else if (state == FEED && !in_valid && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: two instances (N=2/K_MAX=3 and N=4/K_MAX=6)
// driven from directed scenarios and randomized traffic, checked against an
// injection-history reference model (PE(i,j) shows what was injected i+j
// edges ago; done follows the last beat by 2N-2 edges).
module tb_systolic_feeder;

  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         v2, l2, r2, bz2, dn2;
  logic [15:0]  a2, b2;
  logic [31:0]  ma2, mb2;
  logic [3:0]   pv2, pf2;
  logic [1:0]   k2;
  logic         v4, l4, r4, bz4, dn4;
  logic [31:0]  a4, b4;
  logic [127:0] ma4, mb4;
  logic [15:0]  pv4, pf4;
  logic [2:0]   k4;
`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [15:0]  st2, st4;
`endif

  systolic_feeder #(.OP_WIDTH(8), .N(2), .K_MAX(3)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2), .in_last(l2),
    .in_a_col(a2), .in_b_row(b2), .mac_a(ma2), .mac_b(mb2),
    .pe_valid(pv2), .pe_first(pf2), .busy(bz2), .done(dn2), .k_count(k2)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    , .stall_cycles(st2)
`endif
  );

  systolic_feeder #(.OP_WIDTH(8), .N(4), .K_MAX(6)) dut4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .in_last(l4),
    .in_a_col(a4), .in_b_row(b4), .mac_a(ma4), .mac_b(mb4),
    .pe_valid(pv4), .pe_first(pf4), .busy(bz4), .done(dn4), .k_count(k4)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    , .stall_cycles(st4)
`endif
  );

  // stimulus per instance (index 0 = N2, 1 = N4)
  logic [7:0] da [2][4];
  logic [7:0] db [2][4];
  bit         iv [2];
  bit         il [2];

  // reference model
  logic [7:0] ha [2][MAXC][4];
  logic [7:0] hb [2][MAXC][4];
  bit         hv [2][MAXC];
  bit         hf [2][MAXC];
  int         t;
  int         mk [2];
  bit         mrdy [2];
  int         mde [2];
  bit         mdone [2];
  int         mst [2];

  int n_chk = 0;
  int n_fail = 0;

  function automatic int nn(int s); return (s == 0) ? 2 : 4; endfunction
  function automatic int km(int s); return (s == 0) ? 3 : 6; endfunction

  function automatic logic [17:0] pe(int s, int i, int j);
    if (s == 0)
      return {ma2[(i*2+j)*8 +: 8], mb2[(i*2+j)*8 +: 8], pv2[i*2+j], pf2[i*2+j]};
    return {ma4[(i*4+j)*8 +: 8], mb4[(i*4+j)*8 +: 8], pv4[i*4+j], pf4[i*4+j]};
  endfunction

  function automatic logic [10:0] ctl(int s);
    if (s == 0) return {r2, bz2, dn2, 8'(k2)};
    return {r4, bz4, dn4, 8'(k4)};
  endfunction

  function automatic logic [17:0] pk(int a, int b, int v, int f);
    return {8'(a), 8'(b), 1'(v), 1'(f)};
  endfunction

  function automatic logic [10:0] ck(int r, int b, int d, int k);
    return {1'(r), 1'(b), 1'(d), 8'(k)};
  endfunction

  function automatic logic [17:0] e_pe(int s, int i, int j);
    int src = t - i - j;
    if (src < 1) return '0;
    return {ha[s][src][i], hb[s][src][j], hv[s][src], hf[s][src]};
  endfunction

  function automatic logic [10:0] e_ctl(int s);
    return ck(int'(mrdy[s]), int'(mk[s] > 0 || !mrdy[s]), int'(mdone[s]), mk[s]);
  endfunction

`ifdef SYSTOLIC_FEEDER_STATS_EN
  function automatic int g_st(int s); return (s == 0) ? int'(st2) : int'(st4); endfunction
`endif

  task automatic clear_model();
    t = 0;
    for (int s = 0; s < 2; s++) begin
      mk[s] = 0; mrdy[s] = 1'b1; mde[s] = -1; mdone[s] = 1'b0; mst[s] = 0;
    end
  endtask

  task automatic idle_inputs();
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; il[s] = 1'b0;
      for (int k = 0; k < 4; k++) begin da[s][k] = '0; db[s][k] = '0; end
    end
  endtask

  task automatic step();
    bit acc;
    v2 = iv[0]; l2 = il[0]; v4 = iv[1]; l4 = il[1];
    for (int k = 0; k < 2; k++) begin a2[k*8 +: 8] = da[0][k]; b2[k*8 +: 8] = db[0][k]; end
    for (int k = 0; k < 4; k++) begin a4[k*8 +: 8] = da[1][k]; b4[k*8 +: 8] = db[1][k]; end
    @(posedge clk);
    t++;
    if (t >= MAXC) begin
      $display("FAIL history_overflow got t=%0d limit %0d", t, MAXC);
      $fatal(1);
    end
    for (int s = 0; s < 2; s++) begin
      acc = iv[s] && mrdy[s];
      if (mk[s] > 0 && mrdy[s] && !iv[s] && mst[s] < 65535) mst[s]++;
      if (acc && mk[s] == 0) mst[s] = 0;
      hv[s][t] = acc;
      hf[s][t] = acc && (mk[s] == 0);
      for (int k = 0; k < 4; k++) begin
        ha[s][t][k] = acc ? da[s][k] : 8'h0;
        hb[s][t][k] = acc ? db[s][k] : 8'h0;
      end
      mdone[s] = 1'b0;
      if (!mrdy[s] && t == mde[s]) begin
        mdone[s] = 1'b1; mrdy[s] = 1'b1; mk[s] = 0;
      end else if (acc) begin
        mk[s]++;
        if (il[s] || mk[s] == km(s)) begin
          mrdy[s] = 1'b0;
          mde[s]  = t + 2 * nn(s) - 2;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    v2 = 0; l2 = 0; v4 = 0; l4 = 0; a2 = '0; b2 = '0; a4 = '0; b4 = '0;
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if ({ma2, mb2, pv2, pf2, ma4, mb4, pv4, pf4} !== '0) begin
      n_fail++; $display("FAIL reset_grid got pv2=%h pv4=%h exp 0", pv2, pv4);
    end
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if (ctl(s) !== ck(1, 0, 0, 0)) begin
        n_fail++; $display("FAIL reset_ctl%0d got %h exp %h", s, ctl(s), ck(1, 0, 0, 0));
      end
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
    // load the grid, then reset asynchronously mid-cycle
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 2; s++) begin
        iv[s] = 1'b1;
        for (int k = 0; k < 4; k++) begin da[s][k] = 8'(c*16 + k + 1); db[s][k] = 8'(c*16 + k + 9); end
      end
      step();
    end
    n_chk++;
    if (pv2[0] !== 1'b1 || pv4[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_preload got pv2=%h pv4=%h exp bit0 set", pv2, pv4);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({ma2, mb2, pv2, pf2, ma4, mb4, pv4, pf4} !== '0) begin
      n_fail++; $display("FAIL async_reset_grid got pv2=%h pv4=%h ma2=%h exp 0", pv2, pv4, ma2);
    end
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if (ctl(s) !== ck(1, 0, 0, 0)) begin
        n_fail++; $display("FAIL async_reset_ctl%0d got %h exp %h", s, ctl(s), ck(1, 0, 0, 0));
      end
    end
    #1 reset = 1'b0;
    clear_model();
    idle_inputs();
    // aborted matrix must not produce done
    for (int c = 0; c < 8; c++) begin
      step();
      n_chk++;
      if (dn2 !== 1'b0 || dn4 !== 1'b0 || bz2 !== 1'b0 || bz4 !== 1'b0) begin
        n_fail++; $display("FAIL reset_abort_c%0d got done=%b%b busy=%b%b exp 0", c, dn2, dn4, bz2, bz4);
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    iv[0] = 1; da[0][0] = 1; da[0][1] = 2; db[0][0] = 3; db[0][1] = 4;
    step();
    n_chk++; if (pe(0,0,0) !== pk(1,3,1,1)) begin n_fail++; $display("FAIL b2b_e0_pe00 got %h exp %h", pe(0,0,0), pk(1,3,1,1)); end
    n_chk++; if (ctl(0) !== ck(1,1,0,1)) begin n_fail++; $display("FAIL b2b_e0_ctl got %h exp %h", ctl(0), ck(1,1,0,1)); end
    da[0][0] = 5; da[0][1] = 6; db[0][0] = 7; db[0][1] = 8; il[0] = 1;
    step();
    n_chk++; if (pe(0,0,0) !== pk(5,7,1,0)) begin n_fail++; $display("FAIL b2b_e1_pe00 got %h exp %h", pe(0,0,0), pk(5,7,1,0)); end
    n_chk++; if (pe(0,0,1) !== pk(1,4,1,1)) begin n_fail++; $display("FAIL b2b_e1_pe01 got %h exp %h", pe(0,0,1), pk(1,4,1,1)); end
    n_chk++; if (pe(0,1,0) !== pk(2,3,1,1)) begin n_fail++; $display("FAIL b2b_e1_pe10 got %h exp %h", pe(0,1,0), pk(2,3,1,1)); end
    n_chk++; if (ctl(0) !== ck(0,1,0,2)) begin n_fail++; $display("FAIL b2b_e1_ctl got %h exp %h", ctl(0), ck(0,1,0,2)); end
    idle_inputs();
    step();
    n_chk++; if (pe(0,1,1) !== pk(2,4,1,1)) begin n_fail++; $display("FAIL b2b_e2_pe11 got %h exp %h", pe(0,1,1), pk(2,4,1,1)); end
    n_chk++; if (ctl(0) !== ck(0,1,0,2)) begin n_fail++; $display("FAIL b2b_e2_ctl got %h exp %h", ctl(0), ck(0,1,0,2)); end
    step();
    n_chk++; if (pe(0,1,1) !== pk(6,8,1,0)) begin n_fail++; $display("FAIL b2b_e3_pe11 got %h exp %h", pe(0,1,1), pk(6,8,1,0)); end
    n_chk++; if (ctl(0) !== ck(1,0,1,0)) begin n_fail++; $display("FAIL b2b_e3_ctl got %h exp %h", ctl(0), ck(1,0,1,0)); end
    step();
    n_chk++; if (pe(0,1,1) !== pk(0,0,0,0)) begin n_fail++; $display("FAIL b2b_e4_pe11 got %h exp %h", pe(0,1,1), pk(0,0,0,0)); end
    n_chk++; if (ctl(0) !== ck(1,0,0,0)) begin n_fail++; $display("FAIL b2b_e4_ctl got %h exp %h", ctl(0), ck(1,0,0,0)); end
  endtask

  task automatic test_bubble();
    idle_inputs();
    iv[0] = 1; da[0][0] = 11; da[0][1] = 12; db[0][0] = 13; db[0][1] = 14;
    step();
    idle_inputs();
    step();
    n_chk++; if (ctl(0) !== ck(1,1,0,1)) begin n_fail++; $display("FAIL bub_e1_ctl got %h exp %h", ctl(0), ck(1,1,0,1)); end
    n_chk++; if (pe(0,0,0) !== pk(0,0,0,0)) begin n_fail++; $display("FAIL bub_e1_pe00 got %h exp %h", pe(0,0,0), pk(0,0,0,0)); end
    iv[0] = 1; il[0] = 1; da[0][0] = 21; da[0][1] = 22; db[0][0] = 23; db[0][1] = 24;
    step();
    n_chk++; if (pe(0,0,1) !== pk(0,0,0,0)) begin n_fail++; $display("FAIL bub_e2_pe01 got %h exp %h", pe(0,0,1), pk(0,0,0,0)); end
    n_chk++; if (pe(0,0,0) !== pk(21,23,1,0)) begin n_fail++; $display("FAIL bub_e2_pe00 got %h exp %h", pe(0,0,0), pk(21,23,1,0)); end
    n_chk++; if (ctl(0) !== ck(0,1,0,2)) begin n_fail++; $display("FAIL bub_e2_ctl got %h exp %h", ctl(0), ck(0,1,0,2)); end
    idle_inputs();
    step();
    n_chk++; if (pe(0,1,1) !== pk(0,0,0,0)) begin n_fail++; $display("FAIL bub_e3_pe11 got %h exp %h", pe(0,1,1), pk(0,0,0,0)); end
    n_chk++; if (ctl(0) !== ck(0,1,0,2)) begin n_fail++; $display("FAIL bub_e3_ctl got %h exp %h", ctl(0), ck(0,1,0,2)); end
    step();
    n_chk++; if (pe(0,1,1) !== pk(22,24,1,0)) begin n_fail++; $display("FAIL bub_e4_pe11 got %h exp %h", pe(0,1,1), pk(22,24,1,0)); end
    n_chk++; if (ctl(0) !== ck(1,0,1,0)) begin n_fail++; $display("FAIL bub_e4_ctl got %h exp %h", ctl(0), ck(1,0,1,0)); end
    step();
  endtask

  task automatic test_forced_last();
    idle_inputs();
    iv[0] = 1;
    for (int bi = 1; bi <= 3; bi++) begin
      da[0][0] = 8'(bi*10 + 1); da[0][1] = 8'(bi*10 + 2);
      db[0][0] = 8'(bi*10 + 3); db[0][1] = 8'(bi*10 + 4);
      step();
      n_chk++;
      if (ctl(0) !== ck((bi < 3) ? 1 : 0, 1, 0, bi)) begin
        n_fail++; $display("FAIL kmax_beat%0d_ctl got %h exp %h", bi, ctl(0), ck((bi < 3) ? 1 : 0, 1, 0, bi));
      end
    end
    da[0][0] = 41; da[0][1] = 42; db[0][0] = 43; db[0][1] = 44; il[0] = 1;
    step();
    n_chk++; if (ctl(0) !== ck(0,1,0,3)) begin n_fail++; $display("FAIL kmax_e3_ctl got %h exp %h", ctl(0), ck(0,1,0,3)); end
    n_chk++; if (pe(0,0,0) !== pk(0,0,0,0)) begin n_fail++; $display("FAIL kmax_e3_pe00 got %h exp %h", pe(0,0,0), pk(0,0,0,0)); end
    step();
    n_chk++; if (ctl(0) !== ck(1,0,1,0)) begin n_fail++; $display("FAIL kmax_e4_ctl got %h exp %h", ctl(0), ck(1,0,1,0)); end
    n_chk++; if (pe(0,1,1) !== pk(32,34,1,0)) begin n_fail++; $display("FAIL kmax_e4_pe11 got %h exp %h", pe(0,1,1), pk(32,34,1,0)); end
    step();
    n_chk++; if (pe(0,0,0) !== pk(41,43,1,1)) begin n_fail++; $display("FAIL kmax_e5_pe00 got %h exp %h", pe(0,0,0), pk(41,43,1,1)); end
    n_chk++; if (ctl(0) !== ck(0,1,0,1)) begin n_fail++; $display("FAIL kmax_e5_ctl got %h exp %h", ctl(0), ck(0,1,0,1)); end
    idle_inputs();
    step();
    step();
    n_chk++; if (ctl(0) !== ck(1,0,1,0)) begin n_fail++; $display("FAIL kmax_e7_ctl got %h exp %h", ctl(0), ck(1,0,1,0)); end
    n_chk++; if (pe(0,1,1) !== pk(42,44,1,1)) begin n_fail++; $display("FAIL kmax_e7_pe11 got %h exp %h", pe(0,1,1), pk(42,44,1,1)); end
    step();
  endtask

  task automatic test_overlap();
    idle_inputs();
    iv[1] = 1;
    for (int k = 0; k < 4; k++) begin da[1][k] = 8'(1 + k); db[1][k] = 8'(5 + k); end
    step();
    il[1] = 1;
    for (int k = 0; k < 4; k++) begin da[1][k] = 8'(9 + k); db[1][k] = 8'(13 + k); end
    step();
    idle_inputs();
    repeat (5) step();
    n_chk++; if (ctl(1) !== ck(0,1,0,2)) begin n_fail++; $display("FAIL ovl_e6_ctl got %h exp %h", ctl(1), ck(0,1,0,2)); end
    step();
    n_chk++; if (ctl(1) !== ck(1,0,1,0)) begin n_fail++; $display("FAIL ovl_e7_ctl got %h exp %h", ctl(1), ck(1,0,1,0)); end
    n_chk++; if (pe(1,3,3) !== pk(12,16,1,0)) begin n_fail++; $display("FAIL ovl_e7_pe33 got %h exp %h", pe(1,3,3), pk(12,16,1,0)); end
    iv[1] = 1;
    for (int k = 0; k < 4; k++) begin da[1][k] = 8'(21 + k); db[1][k] = 8'(25 + k); end
    step();
    n_chk++; if (pe(1,0,0) !== pk(21,25,1,1)) begin n_fail++; $display("FAIL ovl_e8_pe00 got %h exp %h", pe(1,0,0), pk(21,25,1,1)); end
    n_chk++; if (ctl(1) !== ck(1,1,0,1)) begin n_fail++; $display("FAIL ovl_e8_ctl got %h exp %h", ctl(1), ck(1,1,0,1)); end
    il[1] = 1;
    for (int k = 0; k < 4; k++) begin da[1][k] = 8'(31 + k); db[1][k] = 8'(35 + k); end
    step();
    n_chk++; if (pe(1,0,0) !== pk(31,35,1,0)) begin n_fail++; $display("FAIL ovl_e9_pe00 got %h exp %h", pe(1,0,0), pk(31,35,1,0)); end
    idle_inputs();
    repeat (6) step();
    n_chk++; if (ctl(1) !== ck(1,0,1,0)) begin n_fail++; $display("FAIL ovl_e15_ctl got %h exp %h", ctl(1), ck(1,0,1,0)); end
    n_chk++; if (pe(1,3,3) !== pk(34,38,1,0)) begin n_fail++; $display("FAIL ovl_e15_pe33 got %h exp %h", pe(1,3,3), pk(34,38,1,0)); end
    step();
  endtask

`ifdef SYSTOLIC_FEEDER_STATS_EN
  task automatic test_stats();
    idle_inputs();
    iv[0] = 1; da[0][0] = 7; db[0][0] = 9;
    step();
    n_chk++; if (st2 !== 16'd0) begin n_fail++; $display("FAIL stats_clear1 got %0d exp 0", st2); end
    idle_inputs();
    repeat (3) step();
    n_chk++; if (st2 !== 16'd3) begin n_fail++; $display("FAIL stats_count got %0d exp 3", st2); end
    iv[0] = 1; il[0] = 1;
    step();
    idle_inputs();
    repeat (3) step();
    n_chk++; if (st2 !== 16'd3 || dn2 !== 1'b0 || bz2 !== 1'b0) begin
      n_fail++; $display("FAIL stats_hold got %0d done=%b busy=%b exp 3 0 0", st2, dn2, bz2);
    end
    iv[0] = 1; il[0] = 1;
    step();
    n_chk++; if (st2 !== 16'd0) begin n_fail++; $display("FAIL stats_clear2 got %0d exp 0", st2); end
    idle_inputs();
    repeat (3) step();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int s = 0; s < 2; s++) begin
        iv[s] = ($urandom_range(0, 99) < 65);
        il[s] = ($urandom_range(0, 99) < 25);
        for (int k = 0; k < 4; k++) begin da[s][k] = 8'($urandom); db[s][k] = 8'($urandom); end
      end
      step();
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < nn(s); i++) begin
          for (int j = 0; j < nn(s); j++) begin
            n_chk++;
            if (pe(s, i, j) !== e_pe(s, i, j)) begin
              n_fail++;
              $display("FAIL rand_pe s%0d c%0d (%0d,%0d) got %h exp %h", s, c, i, j, pe(s, i, j), e_pe(s, i, j));
            end
          end
        end
        n_chk++;
        if (ctl(s) !== e_ctl(s)) begin
          n_fail++; $display("FAIL rand_ctl s%0d c%0d got %h exp %h", s, c, ctl(s), e_ctl(s));
        end
`ifdef SYSTOLIC_FEEDER_STATS_EN
        n_chk++;
        if (g_st(s) != mst[s]) begin
          n_fail++; $display("FAIL rand_stall s%0d c%0d got %0d exp %0d", s, c, g_st(s), mst[s]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubble();
    test_forced_last();
    test_overlap();
`ifdef SYSTOLIC_FEEDER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
